// File: rtl/ram_hex_scanner_if.sv
// Read-port bundle between ram_hex_scanner and the 16-byte RAM block.
// master = scanner (drives address/strobe), slave = RAM (returns data).
interface ram_hex_scanner_if #(
    parameter int unsigned AW = 4
);
    logic [AW-1:0] ram_addr;
    logic          ram_ce_n;
    logic [7:0]    ram_data;

    modport master (
        output ram_addr,
        output ram_ce_n,
        input  ram_data
    );

    modport slave (
        input  ram_addr,
        input  ram_ce_n,
        output ram_data
    );
endinterface

// File: rtl/ram_hex_scanner.sv
// ram_hex_scanner: walks the RAM, fetching one byte per pass, and shows it on
// a 7-segment display as two hex digits (high nibble with dp lit, then low
// nibble), each held for DWELL_CYCLES clocks.
// Optional build macro SCAN_SKIP_ZERO_EN: zero bytes are skipped at one fetch
// per cycle, except that a run of RAM_BYTES consecutive zero fetches displays
// the last one so an all-zero RAM still shows something.
module ram_hex_scanner #(
    parameter int unsigned RAM_BYTES    = 16,
    parameter int unsigned DWELL_CYCLES = 5000000,
    localparam int unsigned AW          = $clog2(RAM_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_hex_scanner_if.master     bus,
    input  logic                  run,
    input  logic                  restart,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy,
    output logic [AW-1:0]         cur_addr
);

    localparam int unsigned CW         = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] DwellLast = CW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StShowHi, StShowLo} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ce_n_q, ce_n_d;
    logic          busy_q, busy_d;
`ifdef SCAN_SKIP_ZERO_EN
    logic [AW-1:0] skip_q, skip_d;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state, datapath and registered-output precompute.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef SCAN_SKIP_ZERO_EN
        skip_d  = skip_q;
`endif
        if (restart) begin
            state_d = StIdle;
            ptr_d   = '0;
            cur_d   = '0;
            cnt_d   = '0;
`ifdef SCAN_SKIP_ZERO_EN
            skip_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (run) state_d = StFetch;
                end
                StFetch: begin
                    cnt_d = '0;
`ifdef SCAN_SKIP_ZERO_EN
                    // skip_q counts earlier consecutive zero fetches; the
                    // RAM_BYTES-th zero in a row is shown instead of skipped.
                    if (bus.ram_data == 8'h00 && skip_q != AW'(RAM_BYTES - 1)) begin
                        skip_d  = skip_q + AW'(1);
                        ptr_d   = ptr_q + AW'(1);
                        state_d = run ? StFetch : StIdle;
                    end else begin
                        skip_d  = '0;
                        data_d  = bus.ram_data;
                        cur_d   = ptr_q;
                        state_d = StShowHi;
                    end
`else
                    data_d  = bus.ram_data;
                    cur_d   = ptr_q;
                    state_d = StShowHi;
`endif
                end
                StShowHi: begin
                    if (cnt_q == DwellLast) begin
                        cnt_d   = '0;
                        state_d = StShowLo;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StShowLo: begin
                    if (cnt_q == DwellLast) begin
                        cnt_d   = '0;
                        ptr_d   = ptr_q + AW'(1);
                        state_d = run ? StFetch : StIdle;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end

        // Outputs are derived from the next state so they are registered yet
        // aligned with the state they describe.
        ce_n_d = (state_d != StFetch);
        busy_d = (state_d != StIdle);
        seg_d  = 7'h00;
        dp_d   = 1'b0;
        unique case (state_d)
            StShowHi: begin
                seg_d = hex7(data_d[7:4]);
                dp_d  = 1'b1;
            end
            StShowLo: seg_d = hex7(data_d[3:0]);
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cur_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            ce_n_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SCAN_SKIP_ZERO_EN
            skip_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            ce_n_q  <= ce_n_d;
            busy_q  <= busy_d;
`ifdef SCAN_SKIP_ZERO_EN
            skip_q  <= skip_d;
`endif
        end
    end

    assign bus.ram_addr = ptr_q;
    assign bus.ram_ce_n = ce_n_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign busy         = busy_q;
    assign cur_addr     = cur_q;

endmodule

// File: tb/tb_ram_hex_scanner.sv
// Self-checking bench for ram_hex_scanner. A byte-period model (phase t within
// a 1 + 2*D cycle byte) predicts every output after every clock edge.
module tb_ram_hex_scanner;

    localparam int RB = 16;
    localparam int D  = 4;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       restart;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic [3:0] cur_addr;

    logic [7:0] mem [RB];
    logic [6:0] hex_lut [16];

    ram_hex_scanner_if #(.AW(4)) bus ();
    assign bus.ram_data = mem[bus.ram_addr];

    ram_hex_scanner #(
        .RAM_BYTES   (RB),
        .DWELL_CYCLES(D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .run     (run),
        .restart (restart),
        .seg     (seg),
        .dp      (dp),
        .busy    (busy),
        .cur_addr(cur_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: active = not idle; t = 0 fetch, 1..D high nibble, D+1..2D low.
    bit         m_active;
    int         m_t;
    int         m_ptr;
    int         m_cur;
    int         m_zrun;
    logic [7:0] m_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_ptr    = 0;
        m_cur    = 0;
        m_zrun   = 0;
        m_data   = 8'h00;
    endtask

    task automatic model_step(input logic r, input logic rs);
        logic [7:0] b;
        bit         skip;
        if (rs) begin
            m_active = 0;
            m_t      = 0;
            m_ptr    = 0;
            m_cur    = 0;
            m_zrun   = 0;
        end else if (!m_active) begin
            if (r) begin
                m_active = 1;
                m_t      = 0;
            end
        end else if (m_t == 0) begin
            b    = mem[m_ptr];
            skip = 0;
`ifdef SCAN_SKIP_ZERO_EN
            if (b == 8'h00 && m_zrun < RB - 1) skip = 1;
            m_zrun = skip ? m_zrun + 1 : 0;
`endif
            if (skip) begin
                m_ptr    = (m_ptr + 1) % RB;
                m_active = r;
            end else begin
                m_data = b;
                m_cur  = m_ptr;
                m_t    = 1;
            end
        end else if (m_t < 2 * D) begin
            m_t++;
        end else begin
            m_ptr    = (m_ptr + 1) % RB;
            m_active = r;
            m_t      = 0;
        end
    endtask

    task automatic compare_all();
        check_val("busy", 32'(busy), 32'(m_active));
        check_val("ram_ce_n", 32'(bus.ram_ce_n), 32'(!(m_active && m_t == 0)));
        check_val("cur_addr", 32'(cur_addr), m_cur);
        if (!m_active) begin
            check_val("seg_idle", 32'(seg), 32'h0);
            check_val("dp_idle", 32'(dp), 32'h0);
        end else if (m_t == 0) begin
            check_val("ram_addr", 32'(bus.ram_addr), m_ptr);
        end else if (m_t <= D) begin
            check_val("seg_hi", 32'(seg), 32'(hex_lut[m_data[7:4]]));
            check_val("dp_hi", 32'(dp), 32'h1);
        end else begin
            check_val("seg_lo", 32'(seg), 32'(hex_lut[m_data[3:0]]));
            check_val("dp_lo", 32'(dp), 32'h0);
        end
    endtask

    // One clock: inputs already driven, model advances on the same sample.
    task automatic tick();
        logic r, rs;
        r  = run;
        rs = restart;
        @(posedge clk);
        if (rst_n) model_step(r, rs);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Step until the model shows address a at phase ph; bounded.
    task automatic run_until(input int a, input int ph);
        bit found;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (m_active && m_cur == a && m_t == ph) found = 1;
        end
        check_val("reach_point", 32'(found), 32'h1);
    endtask

    task automatic check_reset_values();
        check_val("rst_seg", 32'(seg), 32'h0);
        check_val("rst_dp", 32'(dp), 32'h0);
        check_val("rst_ce_n", 32'(bus.ram_ce_n), 32'h1);
        check_val("rst_addr", 32'(bus.ram_addr), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_cur", 32'(cur_addr), 32'h0);
    endtask

    initial begin
        hex_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < RB; i++) mem[i] = 8'($urandom_range(1, 255));
        mem[0]  = 8'hA5;
        run     = 1'b0;
        restart = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #12;
        check_reset_values();
        rst_n = 1'b1;

        // Idle with run low.
        ticks(20);

        // Continuous scan: first byte, then wrap past address 15.
        run = 1'b1;
        ticks((1 + 2 * D) * RB + 20);

        // Drop run during high nibble of address 3, then resume.
        run_until(3, 2);
        run = 1'b0;
        ticks(3 * D);
        run = 1'b1;
        ticks(12);

        // Restart together with run during low nibble of address 7.
        run_until(7, D + 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        ticks(12);

        // Mostly-zero RAM with one nonzero byte.
        for (int i = 0; i < RB; i++) mem[i] = 8'h00;
        mem[5]  = 8'h3C;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        ticks(40);

        // All-zero RAM.
        mem[5]  = 8'h00;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        ticks(60);

        // Randomized traffic with sparse zeros, run toggling, rare restarts.
        for (int i = 0; i < RB; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 4) run = ~run;
            restart = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) mem[$urandom_range(0, RB - 1)] = 8'($urandom);
            if (c == 700) begin
                // Asynchronous reset between edges.
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_reset_values();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
